// File: rtl/led_flash_gen.sv
// Stretches single-cycle event pulses into fixed-length active-low LED flashes with a dark gap,
// queueing events that arrive mid-flash in a saturating counter; outputs are all registered.
module led_flash_gen #(
  parameter int ON_CYCLES  = 6_000_000,
  parameter int GAP_CYCLES = 3_000_000,
  parameter int CNT_W      = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pulse_in,
  output logic             led,
  output logic             busy,
  output logic [CNT_W-1:0] pending,
  output logic             overflow
);

  localparam int MAX_C = (ON_CYCLES > GAP_CYCLES) ? ON_CYCLES : GAP_CYCLES;
  localparam int TW    = (MAX_C > 1) ? $clog2(MAX_C) : 1;
  localparam logic [TW-1:0] ON_LOAD  = TW'(ON_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LOAD = TW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ON, GAP} state_t;

  state_t           state_q;
  logic [TW-1:0]    timer_q;
  logic [CNT_W-1:0] pend_q, pend_d;
  logic             ovf_q, ovf_d;
  logic             led_q, busy_q;
  logic             start, tmr_done, consume;

  always_comb begin
    start    = (pend_q != '0) || pulse_in;
    tmr_done = (timer_q == '0);
    consume  = ((state_q == IDLE) && start) ||
               ((state_q == GAP) && tmr_done && start);
    pend_d   = pend_q;
    ovf_d    = ovf_q;
    // A pulse that is itself consumed this cycle nets to no change.
    if (pulse_in && !consume) begin
      if (pend_q == '1) ovf_d = 1'b1;
      else              pend_d = pend_q + CNT_W'(1);
    end else if (!pulse_in && consume) begin
      pend_d = pend_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      timer_q <= '0;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
      led_q   <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      ovf_q  <= ovf_d;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= ON;
            timer_q <= ON_LOAD;
            led_q   <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        ON: begin
          if (tmr_done) begin
            state_q <= GAP;
            timer_q <= GAP_LOAD;
            led_q   <= 1'b1;
          end else begin
            timer_q <= timer_q - TW'(1);
          end
        end
        GAP: begin
          if (tmr_done) begin
            if (start) begin
              state_q <= ON;
              timer_q <= ON_LOAD;
              led_q   <= 1'b0;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            timer_q <= timer_q - TW'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          timer_q <= '0;
          led_q   <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign led      = led_q;
  assign busy     = busy_q;
  assign pending  = pend_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_led_flash_gen.sv
// Directed bench for led_flash_gen with ON=4, GAP=3, CNT_W=2: vector table plus hand-written
// sequences for simultaneous start/pulse and reset mid-flash.
module tb_led_flash_gen;

  logic       clk;
  logic       rst;
  logic       pulse_in;
  logic       led;
  logic       busy;
  logic [1:0] pending;
  logic       overflow;

  led_flash_gen #(.ON_CYCLES(4), .GAP_CYCLES(3), .CNT_W(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .pulse_in (pulse_in),
    .led      (led),
    .busy     (busy),
    .pending  (pending),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       pulse;
    logic       led;
    logic       busy;
    logic [1:0] pend;
    logic       ovf;
  } vec_t;

  vec_t vq[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s [%0d]: got %0d, expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic add(input int n, input logic p, input logic l, input logic b,
                     input logic [1:0] pe, input logic o);
    vec_t v;
    v.pulse = p; v.led = l; v.busy = b; v.pend = pe; v.ovf = o;
    for (int i = 0; i < n; i++) vq.push_back(v);
  endtask

  task automatic step(input logic p);
    pulse_in = p;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    pulse_in = 1'b0;
    #1;
    chk("rst_led", -1, led, 1);
    chk("rst_busy", -1, busy, 0);
    chk("rst_pend", -1, pending, 0);
    chk("rst_ovf", -1, overflow, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    pulse_in = 1'b0;
    #12;
    do_reset();

    // Single pulse: 4 lit cycles, 3 gap cycles, then idle.
    add(1, 1, 0, 1, 0, 0);
    add(3, 0, 0, 1, 0, 0);
    add(3, 0, 1, 1, 0, 0);
    add(2, 0, 1, 0, 0, 0);
    // Queued: pulses at offsets 0, 2, 3; flashes start at 0, 7, 14.
    add(1, 1, 0, 1, 0, 0);
    add(1, 0, 0, 1, 0, 0);
    add(1, 1, 0, 1, 1, 0);
    add(1, 1, 0, 1, 2, 0);
    add(3, 0, 1, 1, 2, 0);
    add(4, 0, 0, 1, 1, 0);
    add(3, 0, 1, 1, 1, 0);
    add(4, 0, 0, 1, 0, 0);
    add(3, 0, 1, 1, 0, 0);
    add(2, 0, 1, 0, 0, 0);
    // Saturation: five pulse cycles, fifth one is dropped at the ON->GAP edge.
    add(1, 1, 0, 1, 0, 0);
    add(1, 1, 0, 1, 1, 0);
    add(1, 1, 0, 1, 2, 0);
    add(1, 1, 0, 1, 3, 0);
    add(1, 1, 1, 1, 3, 1);
    add(2, 0, 1, 1, 3, 1);
    add(4, 0, 0, 1, 2, 1);
    add(3, 0, 1, 1, 2, 1);
    add(4, 0, 0, 1, 1, 1);
    add(3, 0, 1, 1, 1, 1);
    add(4, 0, 0, 1, 0, 1);
    add(3, 0, 1, 1, 0, 1);
    add(3, 0, 1, 0, 0, 1);

    for (int i = 0; i < vq.size(); i++) begin
      step(vq[i].pulse);
      chk("led", i, led, vq[i].led);
      chk("busy", i, busy, vq[i].busy);
      chk("pending", i, pending, vq[i].pend);
      chk("overflow", i, overflow, vq[i].ovf);
    end

    // Simultaneous start and pulse on the final GAP cycle.
    do_reset();
    step(1);
    step(1);
    chk("sim_pend1", 0, pending, 1);
    step(0); step(0);
    step(0);
    chk("sim_gap_led", 0, led, 1);
    step(0); step(0);
    chk("sim_gap_busy", 0, busy, 1);
    step(1);
    chk("sim_start_led", 0, led, 0);
    chk("sim_start_pend", 0, pending, 1);

    // Reset mid-flash with two events queued.
    step(1);
    chk("mid_pend2", 0, pending, 2);
    chk("mid_led_on", 0, led, 0);
    pulse_in = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_led", 0, led, 1);
    chk("mid_rst_pend", 0, pending, 0);
    chk("mid_rst_busy", 0, busy, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(0);
      chk("post_rst_led", i, led, 1);
      chk("post_rst_busy", i, busy, 0);
    end
    chk("post_rst_ovf", 0, overflow, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
